// File: rtl/des_stream_frontend.sv
// Byte-stream front end for the DES control FSM: packs 8 bytes into a block, drives the core, returns the result.
// Optional CBC chaining is enabled by defining DES_CBC_EN; default build is plain ECB.
module des_stream_frontend (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_mode,
  input  logic [63:0] key_in,
  input  logic        key_load,
  input  logic [63:0] iv_in,
  input  logic        iv_load,
  output logic        core_start_encrypt,
  output logic        core_start_decrypt,
  output logic [63:0] core_key,
  output logic [63:0] core_text,
  input  logic        core_done_encrypt,
  input  logic        core_done_decrypt,
  input  logic [63:0] core_output_text,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block
);

  typedef enum logic [1:0] {LOAD, START, SETTLE, OUT} state_t;

  state_t      state;
  logic [63:0] blk_reg;
  logic [2:0]  byte_cnt;
  logic        mode_reg;

  logic        cfg_ok;
  logic        done_any;
  logic [63:0] blk_next;
  logic [63:0] text_next;
  logic [63:0] result;

  // Key/IV writes only between blocks so the core never sees a key change mid-operation.
  assign cfg_ok   = (state == LOAD) && (byte_cnt == 3'd0);
  assign done_any = core_done_encrypt | core_done_decrypt;
  assign blk_next = {blk_reg[55:0], in_byte};

`ifdef DES_CBC_EN
  logic [63:0] chain;
  assign text_next = mode_reg ? blk_next : (blk_next ^ chain);
  assign result    = mode_reg ? (core_output_text ^ chain) : core_output_text;
`else
  logic unused_iv;
  assign unused_iv = ^{iv_in, iv_load};
  assign text_next = blk_next;
  assign result    = core_output_text;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= LOAD;
      blk_reg            <= '0;
      byte_cnt           <= '0;
      mode_reg           <= 1'b0;
      in_ready           <= 1'b1;
      out_valid          <= 1'b0;
      out_block          <= '0;
      core_start_encrypt <= 1'b0;
      core_start_decrypt <= 1'b0;
      core_key           <= '0;
      core_text          <= '0;
`ifdef DES_CBC_EN
      chain              <= '0;
`endif
    end else begin
      if (cfg_ok && key_load) core_key <= key_in;
`ifdef DES_CBC_EN
      if (cfg_ok && iv_load) chain <= iv_in;
`endif
      case (state)
        LOAD: if (in_valid) begin
          blk_reg  <= blk_next;
          byte_cnt <= byte_cnt + 3'd1;
          if (byte_cnt == 3'd0) mode_reg <= in_mode;
          if (byte_cnt == 3'd7) begin
            // core_text is frozen here and held for the whole core run
            in_ready           <= 1'b0;
            core_text          <= text_next;
            core_start_encrypt <= ~mode_reg;
            core_start_decrypt <= mode_reg;
            state              <= START;
          end
        end
        START: if (done_any) begin
          out_block          <= result;
          core_start_encrypt <= 1'b0;
          core_start_decrypt <= 1'b0;
`ifdef DES_CBC_EN
          chain              <= mode_reg ? blk_reg : core_output_text;
`endif
          state              <= SETTLE;
        end
        SETTLE: if (!done_any) begin
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
